// File: rtl/mux_scan_ctrl.sv
// Analog-mux scan sequencer: settles each channel address, fires one ADC conversion per
// channel and streams tagged samples out. Optional ADC timeout via MUX_SCAN_TIMEOUT_EN.
module mux_scan_ctrl #(
    parameter int NUM_CH      = 32,
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 12,
    parameter int SETTLE_CYC  = 50,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic [ADDR_W-1:0] smp_ch,
    output logic [DATA_W-1:0] smp_data,
    output logic              frame_done,
    output logic              busy,
    output logic              err_timeout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_OUT    = 2'd3;

    // One counter times both the settle window and the ADC timeout.
    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [ADDR_W-1:0] LAST_CH     = ADDR_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    logic [1:0]        state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic              adc_start_q,  adc_start_d;
    logic              smp_valid_q,  smp_valid_d;
    logic [ADDR_W-1:0] smp_ch_q,     smp_ch_d;
    logic [DATA_W-1:0] smp_data_q,   smp_data_d;
    logic              frame_done_q, frame_done_d;

`ifdef MUX_SCAN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic err_q, err_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        adc_start_d  = 1'b0;
        smp_valid_d  = smp_valid_q;
        smp_ch_d     = smp_ch_q;
        smp_data_d   = smp_data_q;
        frame_done_d = 1'b0;
`ifdef MUX_SCAN_TIMEOUT_EN
        err_d        = err_q;
`endif

        if (abort) begin
            state_d     = ST_IDLE;
            smp_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
`ifdef MUX_SCAN_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                    end
                end
                ST_SETTLE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == SETTLE_LAST) begin
                        adc_start_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A done strobe in the same cycle as the request belongs to no conversion.
                    if (adc_done && !adc_start_q) begin
                        smp_data_d  = adc_data;
                        smp_ch_d    = addr_q;
                        smp_valid_d = 1'b1;
                        state_d     = ST_OUT;
`ifdef MUX_SCAN_TIMEOUT_EN
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        smp_data_d  = {DATA_W{1'b1}};
                        smp_ch_d    = addr_q;
                        smp_valid_d = 1'b1;
                        err_d       = 1'b1;
                        state_d     = ST_OUT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
`endif
                    end
                end
                ST_OUT: begin
                    if (smp_ready) begin
                        smp_valid_d = 1'b0;
                        cnt_d       = '0;
                        if (addr_q != LAST_CH) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = ST_SETTLE;
                        end else begin
                            frame_done_d = 1'b1;
                            if (continuous) begin
                                addr_d  = '0;
                                state_d = ST_SETTLE;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            adc_start_q  <= 1'b0;
            smp_valid_q  <= 1'b0;
            smp_ch_q     <= '0;
            smp_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            adc_start_q  <= adc_start_d;
            smp_valid_q  <= smp_valid_d;
            smp_ch_q     <= smp_ch_d;
            smp_data_q   <= smp_data_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef MUX_SCAN_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign addr       = addr_q;
    assign adc_start  = adc_start_q;
    assign smp_valid  = smp_valid_q;
    assign smp_ch     = smp_ch_q;
    assign smp_data   = smp_data_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: expected channel order and ADC data are queued by the
// stimulus/ADC model; a negedge monitor checks samples, settle timing, holds and frame_done.
module tb_mux_scan_ctrl;

    localparam int NUM_CH      = 4;
    localparam int ADDR_W      = 6;
    localparam int DATA_W      = 12;
    localparam int SETTLE_CYC  = 5;
    localparam int TIMEOUT_CYC = 20;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              start      = 1'b0;
    logic              continuous = 1'b0;
    logic              abort      = 1'b0;
    logic              adc_done   = 1'b0;
    logic [DATA_W-1:0] adc_data   = '0;
    logic              smp_ready  = 1'b0;
    logic [ADDR_W-1:0] addr;
    logic              adc_start;
    logic              smp_valid;
    logic [ADDR_W-1:0] smp_ch;
    logic [DATA_W-1:0] smp_data;
    logic              frame_done;
    logic              busy;
    logic              err_timeout;

    // Stimulus intent, set on negedges and applied by the single input driver after posedge.
    logic              start_v     = 1'b0;
    logic              abort_v     = 1'b0;
    logic              cont_v      = 1'b0;
    logic              ready_val   = 1'b1;
    logic              rand_ready  = 1'b0;
    logic              man_done_v  = 1'b0;
    logic [DATA_W-1:0] man_data_v  = '0;
    logic              auto_done_v = 1'b0;
    logic [DATA_W-1:0] auto_data_v = '0;
    logic              adc_auto    = 1'b0;
    logic              hang_en     = 1'b0;
    int                adc_fixed   = 0;

    int n_checks    = 0;
    int n_pass      = 0;
    int cyc         = 0;
    int last_launch = 0;
    int fd_count    = 0;
    int busy_falls  = 0;

    int                exp_ch_q[$];
    int                exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];

    mux_scan_ctrl #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
        .addr(addr), .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_ch(smp_ch), .smp_data(smp_data),
        .frame_done(frame_done), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_unexpected(input string name);
        n_checks++;
        $display("FAIL %s: got an event expected none (scoreboard empty)", name);
    endtask

    task automatic push_frame();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            exp_ch_q.push_back(ch);
            exp_addr_q.push_back(ch);
        end
    endtask

    task automatic flush_sb();
        exp_ch_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); start_v = 1'b1;
        @(negedge clk); start_v = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check(name, busy, 0);
    endtask

    task automatic wait_valid(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (smp_valid) break;
            @(negedge clk);
        end
        check(name, smp_valid, 1);
    endtask

    task automatic wait_adc_start(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (adc_start) break;
            @(negedge clk);
        end
        check(name, adc_start, 1);
    endtask

    task automatic wait_fd(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (fd_count >= target) break;
            @(negedge clk);
        end
        check(name, fd_count >= target, 1);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_addr"}, addr, 0);
        check({pfx, "_adc_start"}, adc_start, 0);
        check({pfx, "_smp_valid"}, smp_valid, 0);
        check({pfx, "_smp_ch"}, smp_ch, 0);
        check({pfx, "_smp_data"}, smp_data, 0);
        check({pfx, "_frame_done"}, frame_done, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_err_timeout"}, err_timeout, 0);
    endtask

    // Input driver: the only writer of DUT inputs other than rst_n.
    initial forever begin
        @(posedge clk);
        #1;
        start      = start_v;
        abort      = abort_v;
        continuous = cont_v;
        smp_ready  = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        adc_done   = auto_done_v | man_done_v;
        adc_data   = man_done_v ? man_data_v : auto_data_v;
    end

    // ADC model: answers each request after 1..4 cycles with random data, or hangs on ch2.
    int                adc_cnt  = 0;
    logic [DATA_W-1:0] adc_pend = '0;

    task automatic adc_fire();
        auto_done_v = 1'b1;
        auto_data_v = adc_pend;
        exp_data_q.push_back(adc_pend);
    endtask

    initial forever begin
        int d;
        @(negedge clk);
        auto_done_v = 1'b0;
        if (!rst_n) begin
            adc_cnt = 0;
        end else begin
            if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) adc_fire();
            end
            if (adc_start && adc_auto) begin
                if (hang_en && addr == ADDR_W'(2)) begin
                    exp_data_q.push_back({DATA_W{1'b1}});
                end else begin
                    adc_pend = DATA_W'($urandom);
                    d = (adc_fixed != 0) ? adc_fixed : $urandom_range(1, 4);
                    if (d == 1) adc_fire();
                    else adc_cnt = d - 1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted sample and checks protocol timing.
    logic              prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0;
    logic              prev_adc_start = 1'b0, prev_busy = 1'b0, exp_fd = 1'b0;
    logic [ADDR_W-1:0] prev_ch = '0, prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;

    initial forever begin
        int ec;
        logic [DATA_W-1:0] ed;
        @(negedge clk);
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_adc_start = 1'b0;
            prev_busy = 1'b0;
            exp_fd = 1'b0;
        end else begin
            cyc++;
            if (adc_start) begin
                check("settle_cycles", cyc - last_launch, SETTLE_CYC + 1);
                check("adc_start_width", prev_adc_start, 0);
                if (exp_addr_q.size() == 0) fail_unexpected("adc_start_extra");
                else check("adc_start_addr", addr, exp_addr_q.pop_front());
            end
            if (prev_valid && !prev_ready && !prev_abort) begin
                check("hold_valid", smp_valid, 1);
                check("hold_ch", smp_ch, prev_ch);
                check("hold_data", smp_data, prev_data);
                check("hold_addr", addr, prev_addr);
            end
            if (frame_done || exp_fd) check("frame_done", frame_done, exp_fd);
            if (frame_done) fd_count++;
            exp_fd = 1'b0;
            if (smp_valid && smp_ready && !abort) begin
                last_launch = cyc;
                if (exp_ch_q.size() == 0 || exp_data_q.size() == 0) begin
                    fail_unexpected("smp_extra");
                end else begin
                    ec = exp_ch_q.pop_front();
                    ed = exp_data_q.pop_front();
                    check("smp_ch", smp_ch, ec);
                    check("smp_data", smp_data, ed);
                    check("out_addr", addr, ec);
                    exp_fd = (ec == NUM_CH - 1);
                end
            end
            if (start && !busy && !abort) last_launch = cyc;
            if (prev_busy && !busy) busy_falls++;
            prev_valid     = smp_valid;
            prev_ready     = smp_ready;
            prev_abort     = abort;
            prev_adc_start = adc_start;
            prev_busy      = busy;
            prev_ch        = smp_ch;
            prev_data      = smp_data;
            prev_addr      = addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        int fd0, bf0;
        logic [DATA_W-1:0] d;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, fixed 3-cycle ADC, ready tied high.
        adc_auto = 1'b1; adc_fixed = 3; rand_ready = 1'b0; ready_val = 1'b1;
        fd0 = fd_count; bf0 = busy_falls;
        push_frame();
        pulse_start();
        wait_idle(300, "t1_idle");
        @(negedge clk);
        check("t1_frames", fd_count - fd0, 1);
        check("t1_busy_fall", busy_falls - bf0, 1);
        check("t1_addr_last", addr, NUM_CH - 1);
        check("t1_drain", exp_ch_q.size() + exp_addr_q.size() + exp_data_q.size(), 0);

        // Back-pressure: long stall on ch1 with an ignored start in the middle.
        adc_fixed = 0; ready_val = 1'b0;
        push_frame();
        pulse_start();
        for (int k = 0; k < NUM_CH; k++) begin
            wait_valid(200, "t3_valid");
            if (k == 1) begin
                repeat (4) @(negedge clk);
                pulse_start();
                repeat (4) @(negedge clk);
            end else begin
                @(negedge clk);
            end
            ready_val = 1'b1;
            @(negedge clk); ready_val = 1'b0;
            @(negedge clk);
        end
        wait_idle(300, "t3_idle");
        check("t3_drain", exp_ch_q.size() + exp_addr_q.size() + exp_data_q.size(), 0);

        // Continuous mode across two frames, dropped during the second.
        rand_ready = 1'b1;
        fd0 = fd_count; bf0 = busy_falls;
        push_frame(); push_frame();
        cont_v = 1'b1;
        pulse_start();
        wait_fd(fd0 + 1, 600, "t4_first_frame");
        cont_v = 1'b0;
        wait_idle(600, "t4_idle");
        @(negedge clk);
        check("t4_frames", fd_count - fd0, 2);
        check("t4_busy_fall", busy_falls - bf0, 1);
        check("t4_drain", exp_ch_q.size() + exp_addr_q.size() + exp_data_q.size(), 0);

        // Done strobe coincident with adc_start must be ignored.
        rand_ready = 1'b0; ready_val = 1'b1; adc_auto = 1'b0;
        push_frame();
        pulse_start();
        repeat (SETTLE_CYC - 1) @(negedge clk);
        man_data_v = 12'hA5A; man_done_v = 1'b1;
        @(negedge clk); man_done_v = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_glitch_ignored", smp_valid, 0);
        check("t5_glitch_busy", busy, 1);
        d = DATA_W'($urandom);
        exp_data_q.push_back(d);
        man_data_v = d; man_done_v = 1'b1; adc_auto = 1'b1;
        @(negedge clk); man_done_v = 1'b0;
        wait_idle(300, "t5_glitch_idle");
        check("t5_glitch_drain", exp_ch_q.size() + exp_addr_q.size() + exp_data_q.size(), 0);

        // Abort in WAIT together with adc_done.
        adc_auto = 1'b0;
        push_frame();
        pulse_start();
        wait_adc_start(100, "t5_abort_req");
        man_data_v = 12'h3C3; man_done_v = 1'b1; abort_v = 1'b1;
        @(negedge clk); man_done_v = 1'b0; abort_v = 1'b0;
        @(negedge clk);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_valid", smp_valid, 0);
        check("t5_abort_adc_start", adc_start, 0);
        check("t5_abort_frame_done", frame_done, 0);
        check("t5_abort_addr", addr, 0);
        repeat (5) @(negedge clk);
        check("t5_abort_valid_later", smp_valid, 0);
        flush_sb();

        // Abort beats a simultaneous start in IDLE.
        start_v = 1'b1; abort_v = 1'b1;
        @(negedge clk); start_v = 1'b0; abort_v = 1'b0;
        @(negedge clk);
        check("t5_abort_start_busy", busy, 0);

        // Reset while a sample is stalled in OUT.
        adc_auto = 1'b1; ready_val = 1'b0;
        push_frame();
        pulse_start();
        wait_valid(200, "t5_reset_valid");
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_reset");
        flush_sb();
        @(negedge clk); rst_n = 1'b1;
        ready_val = 1'b1;
        repeat (2) @(negedge clk);

        // Random back-pressure and ADC latency.
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            push_frame();
            pulse_start();
            wait_idle(600, "rand_idle");
        end
        check("rand_drain", exp_ch_q.size() + exp_addr_q.size() + exp_data_q.size(), 0);

`ifdef MUX_SCAN_TIMEOUT_EN
        hang_en = 1'b1;
        push_frame();
        pulse_start();
        wait_idle(800, "t6_idle");
        check("t6_err_set", err_timeout, 1);
        check("t6_drain", exp_ch_q.size() + exp_addr_q.size() + exp_data_q.size(), 0);
        hang_en = 1'b0;
        push_frame();
        pulse_start();
        check("t6_err_cleared", err_timeout, 0);
        wait_idle(600, "t6_idle2");
        check("t6_drain2", exp_ch_q.size() + exp_addr_q.size() + exp_data_q.size(), 0);
`else
        check("err_tied_low", err_timeout, 0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
